// File: rtl/ch_fifo.sv
// ch_fifo: 512-deep first-word-fall-through FIFO with occupancy-decoded status flags.
// The head word is always visible on dout; a read simply advances the read pointer.
module ch_fifo #(
  parameter int DATA_WIDTH       = 65,
  parameter int ADDR_WIDTH       = 9,
  parameter int PROG_FULL_THRESH = 256
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  prog_full,
  output logic                  prog_empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT        = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ALMOST_FULL_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] THRESH_CNT      = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT         = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_accept;
  logic                  rd_accept;

  // A write while full is dropped even if a read frees a slot in the same cycle.
  assign wr_accept = wr_en & ~full & rst_n;
  assign rd_accept = rd_en & ~empty;

  always_ff @(posedge wb_clk_i) begin
    if (wr_accept) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

  // Flags come straight from the registered count, so they settle with the pointers.
  assign empty        = (count == '0);
  assign almost_empty = (count <= ONE_CNT);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= ALMOST_FULL_CNT);
  assign prog_full    = (count >= THRESH_CNT);
  assign prog_empty   = (count < THRESH_CNT);

endmodule

// File: tb/tb_ch_fifo.sv
// tb_ch_fifo: directed and randomized scoreboard bench for ch_fifo.
// A queue-based reference tracks contents; a negedge monitor checks dout and every flag.
module tb_ch_fifo;

  localparam int DW    = 65;
  localparam int DEPTH = 512;
  localparam int THR   = 256;

  logic          wb_clk_i;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic          almost_empty;
  logic          full;
  logic          almost_full;
  logic          prog_full;
  logic          prog_empty;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [$];
  int            model_count = 0;

  ch_fifo #(
    .DATA_WIDTH       (DW),
    .ADDR_WIDTH       (9),
    .PROG_FULL_THRESH (THR)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .rst_n        (rst_n),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .almost_empty (almost_empty),
    .full         (full),
    .almost_full  (almost_full),
    .prog_full    (prog_full),
    .prog_empty   (prog_empty)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [5:0] flags_for(input int c);
    return {c == 0, c <= 1, c == DEPTH, c >= DEPTH - 1, c >= THR, c < THR};
  endfunction

  task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [5:0] exp_flags);
    check_val(name, DW'({empty, almost_empty, full, almost_full, prog_full, prog_empty}), DW'(exp_flags));
  endtask

  task automatic apply_stimulus(input logic wr, input logic rd, input logic [DW-1:0] d);
    @(posedge wb_clk_i);
    #1;
    wr_en = wr;
    rd_en = rd;
    din   = d;
  endtask

  // Reference: accepted writes enqueue expected words; occupancy follows the plain rules.
  always @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      automatic bit wa = wr_en && (model_count < DEPTH);
      automatic bit ra = rd_en && (model_count > 0);
      if (wa) exp_q.push_back(din);
      model_count = model_count + int'(wa) - int'(ra);
    end
  end

  // Monitor: mid-cycle, compare flags and the presented head; pop on a read handshake.
  always @(negedge wb_clk_i) begin
    check_output("mon_flags", flags_for(model_count));
    if (model_count > 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL mon_queue: got empty scoreboard expected %0d entries", model_count);
      end else begin
        check_val("mon_dout", dout, exp_q[0]);
        if (rd_en) void'(exp_q.pop_front());
      end
    end
  end

  localparam logic [5:0] RESET_FLAGS = 6'b110001;

  initial begin
    logic [95:0] rnd;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    #1;
    check_output("reset_flags", RESET_FLAGS);
    repeat (3) @(posedge wb_clk_i);
    #3 rst_n = 1'b1;

    // Single tagged word in, then popped.
    apply_stimulus(1'b1, 1'b0, 65'h1_0000_0000_0000_00AA);
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("one_word_flags", 6'b010001);
    check_val("one_word_dout", dout, 65'h1_0000_0000_0000_00AA);
    apply_stimulus(1'b0, 1'b1, '0);
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("one_word_popped", RESET_FLAGS);

    // Fill to 512 with flag thresholds observed on the way.
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, 1'b0, DW'(i));
      if (i == 2)   check_val("fill_almost_empty_fell", DW'(almost_empty), DW'(0));
      if (i == 255) check_output("fill_255", 6'b000001);
      if (i == 256) check_output("fill_256", 6'b000010);
      if (i == 510) check_output("fill_510", 6'b000010);
      if (i == 511) check_output("fill_511", 6'b000110);
    end
    apply_stimulus(1'b1, 1'b0, 65'h999);
    check_output("fill_512", 6'b001110);
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("overflow_ignored", 6'b001110);

    // Full with read+write: the write is dropped, count drops to 511.
    apply_stimulus(1'b1, 1'b1, 65'h777);
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("full_rw_511", 6'b000110);

    for (int i = 1; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b1, '0);
      check_val("drain_order", dout, DW'(i));
    end
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("drained", RESET_FLAGS);
    apply_stimulus(1'b0, 1'b1, '0);
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("underflow_ignored", RESET_FLAGS);

    // Count of one with read+write: new word replaces the head.
    apply_stimulus(1'b1, 1'b0, 65'hABC);
    apply_stimulus(1'b1, 1'b1, 65'h1_0000_0000_0000_0DEF);
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("one_rw_flags", 6'b010001);
    check_val("one_rw_dout", dout, 65'h1_0000_0000_0000_0DEF);
    apply_stimulus(1'b0, 1'b1, '0);
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("one_rw_popped", RESET_FLAGS);

    // Randomized traffic with a mid-stream asynchronous reset.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      rnd = {$urandom, $urandom, $urandom};
      if (cyc == 500) begin
        @(posedge wb_clk_i);
        #3 rst_n = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1;
        check_output("async_reset_flags", RESET_FLAGS);
        repeat (2) @(posedge wb_clk_i);
        #1;
        check_output("reset_held_flags", RESET_FLAGS);
        #2 rst_n = 1'b1;
      end
      apply_stimulus(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60), rnd[DW-1:0]);
    end
    apply_stimulus(1'b0, 1'b0, '0);
    repeat (2) @(posedge wb_clk_i);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
